// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: computes at issue, models latency, commits on completion.
// Optional abort input enabled by defining MD_SCHED_ABORT_EN.
module md_sched #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef MD_SCHED_ABORT_EN
   input  logic        abort,
`endif
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        we_hilo,
   input  logic        write_sel,
   input  logic        md_in_D,
   output logic        busy,
   output logic        stall_md,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        shadow_hi_q, shadow_hi_d;
   logic [31:0]        shadow_lo_q, shadow_lo_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               done_q, done_d;
   logic               abort_w;

`ifdef MD_SCHED_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   logic [63:0] prod_s, prod_u;
   logic [31:0] div_b, quot_s, rem_s, quot_u, rem_u;
   logic        div_ovf;
   logic [31:0] res_hi, res_lo;
   logic [CNT_W-1:0] start_cnt;

   assign prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u  = {32'b0, A} * {32'b0, B};
   // Divisor forced non-zero so the divider never sees 0; B==0 result is discarded below.
   assign div_b   = (B == 32'b0) ? 32'd1 : B;
   assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign quot_s  = $signed(A) / $signed(div_b);
   assign rem_s   = $signed(A) % $signed(div_b);
   assign quot_u  = A / div_b;
   assign rem_u   = A % div_b;

   assign start_cnt = op[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);

   // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      unique case (op)
         2'b00: {res_hi, res_lo} = prod_s;
         2'b01: {res_hi, res_lo} = prod_u;
         2'b10: begin
            if (div_ovf) begin
               res_hi = 32'b0;
               res_lo = 32'h8000_0000;
            end else if (B != 32'b0) begin
               res_hi = rem_s;
               res_lo = quot_s;
            end
         end
         2'b11: begin
            if (B != 32'b0) begin
               res_hi = rem_u;
               res_lo = quot_u;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_hi_d = shadow_hi_q;
      shadow_lo_d = shadow_lo_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !abort_w) begin
               shadow_hi_d = res_hi;
               shadow_lo_d = res_lo;
               cnt_d       = start_cnt;
               state_d     = StRun;
            end else if (we_hilo && !start) begin
               if (write_sel) hi_d = A;
               else           lo_d = A;
            end
         end
         StRun: begin
            if (abort_w) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else if (cnt_q == '0) begin
               hi_d    = shadow_hi_q;
               lo_d    = shadow_lo_q;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shadow_hi_q <= '0;
         shadow_lo_q <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_hi_q <= shadow_hi_d;
         shadow_lo_q <= shadow_lo_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         done_q      <= done_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign stall_md = md_in_D & (busy | start);
   assign done     = done_q;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: per-cycle model comparison plus directed literal checks.
// Abort scenarios are exercised when MD_SCHED_ABORT_EN is defined.
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        we_hilo = 1'b0;
   logic        write_sel = 1'b0;
   logic        md_in_D = 1'b0;
   logic        abort = 1'b0;
   logic        busy, stall_md, done;
   logic [31:0] HI, LO;

   md_sched dut (
      .clk       (clk),
      .reset     (reset),
`ifdef MD_SCHED_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .op        (op),
      .A         (A),
      .B         (B),
      .we_hilo   (we_hilo),
      .write_sel (write_sel),
      .md_in_D   (md_in_D),
      .busy      (busy),
      .stall_md  (stall_md),
      .done      (done),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference result straight from the arithmetic rules.
   function automatic logic [63:0] model_calc(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
      int     ia, ib, q, r;
      longint p;
      case (o)
         2'b00: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
         end
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'b0) return {hi, lo};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            ia = a;
            ib = b;
            q  = ia / ib;
            r  = ia - q * ib;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 32'b0) return {hi, lo};
            return {a % b, a / b};
         end
      endcase
   endfunction

   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   int          m_rem;
   logic        m_done;
   logic        ab;

`ifdef MD_SCHED_ABORT_EN
   assign ab = abort;
`else
   assign ab = 1'b0;
`endif

   // m_rem = busy cycles still to run (0 = idle).
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_pend <= '0;
         m_rem  <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem > 0) begin
            if (ab) m_rem <= 0;
            else if (m_rem == 1) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_done <= 1'b1;
               m_rem  <= 0;
            end else m_rem <= m_rem - 1;
         end else if (start && !ab) begin
            m_pend <= model_calc(op, A, B, m_hi, m_lo);
            m_rem  <= op[1] ? 10 : 5;
         end else if (we_hilo && !start) begin
            if (write_sel) m_hi <= A;
            else           m_lo <= A;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
      chk("stall_md", {31'b0, stall_md}, {31'b0, md_in_D & ((m_rem != 0) | start)});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      tick();
      start = 1'b0;
   endtask

   task automatic hilo_write(input logic sel, input logic [31:0] v);
      we_hilo   = 1'b1;
      write_sel = sel;
      A         = v;
      tick();
      we_hilo   = 1'b0;
   endtask

   task automatic window(input int n, output int nb, output int nd, output int ns);
      nb = 0;
      nd = 0;
      ns = 0;
      repeat (n) begin
         @(negedge clk);
         nb += int'(busy);
         nd += int'(done);
         ns += int'(stall_md);
      end
      tick();
   endtask

   int nb, nd, ns;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset HI", HI, 32'd0);
      chk("reset LO", LO, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // mult -2 * 3
      do_start(2'b00, 32'hFFFF_FFFE, 32'd3);
      window(8, nb, nd, ns);
      chk("mult busy cycles", nb, 32'd5);
      chk("mult done pulses", nd, 32'd1);
      chk("mult HI", HI, 32'hFFFF_FFFF);
      chk("mult LO", LO, 32'hFFFF_FFFA);

      // divu 100 / 7 with a HI/LO user held in D
      md_in_D = 1'b1;
      start = 1'b1;
      op    = 2'b11;
      A     = 32'd100;
      B     = 32'd7;
      #2;
      chk("stall in start cycle", {31'b0, stall_md}, 32'd1);
      tick();
      start = 1'b0;
      window(13, nb, nd, ns);
      md_in_D = 1'b0;
      chk("divu busy cycles", nb, 32'd10);
      chk("divu stall cycles", ns, 32'd10);
      chk("divu LO", LO, 32'd14);
      chk("divu HI", HI, 32'd2);

      // div -7 / 2
      do_start(2'b10, 32'hFFFF_FFF9, 32'd2);
      window(13, nb, nd, ns);
      chk("div LO", LO, 32'hFFFF_FFFD);
      chk("div HI", HI, 32'hFFFF_FFFF);

      // mtlo then div by zero with a colliding mthi
      hilo_write(1'b0, 32'h1234);
      chk("mtlo", LO, 32'h1234);
      we_hilo   = 1'b1;
      write_sel = 1'b1;
      do_start(2'b10, 32'h55, 32'd0);
      we_hilo   = 1'b0;
      window(13, nb, nd, ns);
      chk("div0 busy cycles", nb, 32'd10);
      chk("div0 LO", LO, 32'h1234);
      chk("div0 HI", HI, 32'hFFFF_FFFF);

      // signed overflow case
      do_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      window(13, nb, nd, ns);
      chk("div ovf LO", LO, 32'h8000_0000);
      chk("div ovf HI", HI, 32'h0);

      // start and mthi/mtlo while busy are ignored
      do_start(2'b00, 32'd3, 32'd4);
      we_hilo   = 1'b1;
      write_sel = 1'b0;
      do_start(2'b11, 32'd100, 32'd0);
      we_hilo   = 1'b0;
      window(8, nb, nd, ns);
      chk("busy-ignore done", nd, 32'd1);
      chk("busy-ignore LO", LO, 32'd12);
      chk("busy-ignore HI", HI, 32'd0);

      // reset mid-run
      do_start(2'b00, 32'd7, 32'd7);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("mid reset busy", {31'b0, busy}, 32'd0);
      chk("mid reset LO", LO, 32'd0);
      chk("mid reset done", {31'b0, done}, 32'd0);
      tick();
      reset = 1'b1;
      window(8, nb, nd, ns);
      chk("mid reset no done", nd, 32'd0);

`ifdef MD_SCHED_ABORT_EN
      hilo_write(1'b0, 32'h77);
      hilo_write(1'b1, 32'h66);
      do_start(2'b11, 32'd9, 32'd2);
      tick();
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort busy", {31'b0, busy}, 32'd0);
      window(12, nb, nd, ns);
      chk("abort no done", nd, 32'd0);
      chk("abort LO", LO, 32'h77);
      chk("abort HI", HI, 32'h66);
      abort = 1'b1;
      do_start(2'b00, 32'd5, 32'd5);
      abort = 1'b0;
      chk("abort suppresses start", {31'b0, busy}, 32'd0);
      do_start(2'b01, 32'd3, 32'd4);
      window(8, nb, nd, ns);
      chk("post-abort multu LO", LO, 32'd12);
      chk("post-abort multu HI", HI, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
